dice_game_ctrl: RTL and testbench

Controller that sequences the two free-running dice counters (3-bit, values 1..6) and plays one game of craps with them. It gates the counters while the player holds `roll`, captures both dice on release, and evaluates the come-out roll and any point rolls. It reports win or lose and holds the result until a new game starts. It sits between the roll/new-game inputs and the dice counters, and its outputs drive the display logic.

---
 rtl/dice_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_dice_game_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dice_game_ctrl.sv
// dice_game_ctrl: gates the two dice counters, captures a roll on release and
// plays one game of craps, holding win/lose until a new game starts.
`default_nettype none

module dice_game_ctrl #(
  parameter int MIN_ROLL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll,
  input  logic       new_game,
  input  logic [2:0] dice1_in,
  input  logic [2:0] dice2_in,
  output logic       count_en,
  output logic [2:0] dice1_q,
  output logic [2:0] dice2_q,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic [7:0] roll_num,
  output logic       win,
  output logic       lose
);

  localparam logic [7:0] MIN_RC = 8'(MIN_ROLL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROLL  = 3'd1,
    EVAL  = 3'd2,
    PWAIT = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  state_t     state, state_nx;
  logic       come_out, come_out_nx;
  logic [7:0] rc, rc_nx, rc_inc;
  logic       count_en_nx;
  logic [2:0] dice1_nx, dice2_nx;
  logic [3:0] sum_nx, point_nx;
  logic [7:0] roll_num_nx;
  logic       win_nx, lose_nx;
  logic       dice_legal;

  assign dice_legal = (dice1_in != 3'd0) && (dice1_in != 3'd7) &&
                      (dice2_in != 3'd0) && (dice2_in != 3'd7);
  // The capture test uses the post-increment count so count_en spans exactly MIN_ROLL cycles.
  assign rc_inc = (rc >= MIN_RC) ? rc : rc + 8'd1;

  always_comb begin
    state_nx    = state;
    come_out_nx = come_out;
    rc_nx       = rc;
    dice1_nx    = dice1_q;
    dice2_nx    = dice2_q;
    sum_nx      = sum;
    point_nx    = point;
    roll_num_nx = roll_num;
    win_nx      = win;
    lose_nx     = lose;

    if (new_game) begin
      state_nx    = IDLE;
      come_out_nx = 1'b1;
      rc_nx       = 8'd0;
      dice1_nx    = 3'd0;
      dice2_nx    = 3'd0;
      sum_nx      = 4'd0;
      point_nx    = 4'd0;
      roll_num_nx = 8'd0;
      win_nx      = 1'b0;
      lose_nx     = 1'b0;
    end else begin
      case (state)
        IDLE, PWAIT: begin
          if (roll) begin
            state_nx = ROLL;
            rc_nx    = 8'd0;
          end
        end
        ROLL: begin
          rc_nx = rc_inc;
          if (!roll && (rc_inc >= MIN_RC) && dice_legal) begin
            dice1_nx    = dice1_in;
            dice2_nx    = dice2_in;
            sum_nx      = {1'b0, dice1_in} + {1'b0, dice2_in};
            roll_num_nx = (roll_num == 8'hFF) ? roll_num : roll_num + 8'd1;
            state_nx    = EVAL;
          end
        end
        EVAL: begin
          if (come_out) begin
            case (sum)
              4'd7, 4'd11: begin
                state_nx = WIN;
                win_nx   = 1'b1;
              end
              4'd2, 4'd3, 4'd12: begin
                state_nx = LOSE;
                lose_nx  = 1'b1;
              end
              default: begin
                point_nx    = sum;
                come_out_nx = 1'b0;
                state_nx    = PWAIT;
              end
            endcase
          end else if (sum == point) begin
            state_nx = WIN;
            win_nx   = 1'b1;
          end else if (sum == 4'd7) begin
            state_nx = LOSE;
            lose_nx  = 1'b1;
          end else begin
            state_nx = PWAIT;
          end
        end
        WIN, LOSE: state_nx = state;
        default:   state_nx = IDLE;
      endcase
    end

    count_en_nx = (state_nx == ROLL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      come_out <= 1'b1;
      rc       <= 8'd0;
      count_en <= 1'b0;
      dice1_q  <= 3'd0;
      dice2_q  <= 3'd0;
      sum      <= 4'd0;
      point    <= 4'd0;
      roll_num <= 8'd0;
      win      <= 1'b0;
      lose     <= 1'b0;
    end else begin
      state    <= state_nx;
      come_out <= come_out_nx;
      rc       <= rc_nx;
      count_en <= count_en_nx;
      dice1_q  <= dice1_nx;
      dice2_q  <= dice2_nx;
      sum      <= sum_nx;
      point    <= point_nx;
      roll_num <= roll_num_nx;
      win      <= win_nx;
      lose     <= lose_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: per-cycle vector table plus directed sequences.
`default_nettype none

module tb_dice_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, roll, new_game;
  logic [2:0] dice1_in, dice2_in;
  logic       count_en;
  logic [2:0] dice1_q, dice2_q;
  logic [3:0] sum, point;
  logic [7:0] roll_num;
  logic       win, lose;

  int tests = 0;
  int fails = 0;

  dice_game_ctrl #(.MIN_ROLL(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .roll     (roll),
    .new_game (new_game),
    .dice1_in (dice1_in),
    .dice2_in (dice2_in),
    .count_en (count_en),
    .dice1_q  (dice1_q),
    .dice2_q  (dice2_q),
    .sum      (sum),
    .point    (point),
    .roll_num (roll_num),
    .win      (win),
    .lose     (lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, roll, ng;
    logic [2:0] d1, d2;
    logic       ce;
    logic [2:0] d1q, d2q;
    logic [3:0] sum, point;
    logic [7:0] rn;
    logic       win, lose;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic add(input logic r, rl, ng, input logic [2:0] a, b,
                     input logic ce, input logic [2:0] aq, bq,
                     input logic [3:0] s, p, input logic [7:0] rn,
                     input logic w, l);
    vecs[nv] = '{r, rl, ng, a, b, ce, aq, bq, s, p, rn, w, l};
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold roll for 'hold' cycles, release, wait for capture, then the decision edge.
  task automatic do_roll(input logic [2:0] a, input logic [2:0] b, input int hold);
    int n;
    dice1_in = a;
    dice2_in = b;
    roll = 1'b1;
    repeat (hold) tick();
    roll = 1'b0;
    n = 0;
    while (count_en && n < 20) begin
      tick();
      n++;
    end
    check("capture_timeout", {31'd0, count_en}, 32'd0);
    tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; roll = 1'b0; new_game = 1'b0; dice1_in = 3'd1; dice2_in = 3'd1;

    // Reset, 6-cycle roll that wins on the come-out, win held against roll.
    add(1,0,0,3,4, 0,0,0, 0,0,0,0,0);
    add(1,0,0,3,4, 0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 6; i++) add(0,1,0,3,4, 1,0,0, 0,0,0,0,0);
    add(0,0,0,3,4, 0,3,4, 7,0,1,0,0);
    add(0,0,0,3,4, 0,3,4, 7,0,1,1,0);
    add(0,1,0,5,5, 0,3,4, 7,0,1,1,0);
    add(0,1,0,5,5, 0,3,4, 7,0,1,1,0);
    add(0,0,0,5,5, 0,3,4, 7,0,1,1,0);
    add(0,0,1,5,5, 0,0,0, 0,0,0,0,0);
    // Come-out lose on boxcars with a 5-cycle roll.
    for (int i = 0; i < 5; i++) add(0,1,0,6,6, 1,0,0, 0,0,0,0,0);
    add(0,0,0,6,6, 0,6,6, 12,0,1,0,0);
    add(0,0,0,6,6, 0,6,6, 12,0,1,0,1);
    add(0,1,0,6,6, 0,6,6, 12,0,1,0,1);
    add(0,0,1,6,6, 0,0,0, 0,0,0,0,0);

    for (int i = 0; i < nv; i++) begin
      rst = vecs[i].rst; roll = vecs[i].roll; new_game = vecs[i].ng;
      dice1_in = vecs[i].d1; dice2_in = vecs[i].d2;
      tick();
      check($sformatf("v%0d count_en", i), {31'd0, count_en}, {31'd0, vecs[i].ce});
      check($sformatf("v%0d dice1_q", i),  {29'd0, dice1_q},  {29'd0, vecs[i].d1q});
      check($sformatf("v%0d dice2_q", i),  {29'd0, dice2_q},  {29'd0, vecs[i].d2q});
      check($sformatf("v%0d sum", i),      {28'd0, sum},      {28'd0, vecs[i].sum});
      check($sformatf("v%0d point", i),    {28'd0, point},    {28'd0, vecs[i].point});
      check($sformatf("v%0d roll_num", i), {24'd0, roll_num}, {24'd0, vecs[i].rn});
      check($sformatf("v%0d win", i),      {31'd0, win},      {31'd0, vecs[i].win});
      check($sformatf("v%0d lose", i),     {31'd0, lose},     {31'd0, vecs[i].lose});
    end
    new_game = 1'b0; roll = 1'b0;

    // Point of 5, then 8 (no decision), then 5 wins.
    do_roll(3'd2, 3'd3, 5);
    check("pt1 point", {28'd0, point}, 32'd5);
    check("pt1 win_lose", {30'd0, win, lose}, 32'd0);
    do_roll(3'd4, 3'd4, 5);
    check("pt2 sum", {28'd0, sum}, 32'd8);
    check("pt2 roll_num", {24'd0, roll_num}, 32'd2);
    check("pt2 win_lose", {30'd0, win, lose}, 32'd0);
    do_roll(3'd1, 3'd4, 5);
    check("pt3 win", {31'd0, win}, 32'd1);
    check("pt3 roll_num", {24'd0, roll_num}, 32'd3);
    new_game = 1'b1; tick(); new_game = 1'b0;
    // Same point, then seven-out.
    do_roll(3'd2, 3'd3, 5);
    do_roll(3'd4, 3'd4, 5);
    do_roll(3'd3, 3'd4, 5);
    check("sevenout lose", {30'd0, win, lose}, 32'd1);
    check("sevenout point", {28'd0, point}, 32'd5);
    new_game = 1'b1; tick(); new_game = 1'b0;

    // One-cycle roll request still spins for MIN_ROLL cycles.
    dice1_in = 3'd2; dice2_in = 3'd2;
    roll = 1'b1; tick(); roll = 1'b0;
    cnt = 0;
    repeat (10) begin
      if (count_en) cnt++;
      tick();
    end
    check("short count_en cycles", cnt, 32'd4);
    check("short point", {28'd0, point}, 32'd4);

    // Illegal die for 2 cycles delays capture from PWAIT.
    dice1_in = 3'd3; dice2_in = 3'd3;
    roll = 1'b1; tick(); roll = 1'b0;
    repeat (3) tick();
    dice1_in = 3'd7;
    tick();
    check("illegal ce hold1", {31'd0, count_en}, 32'd1);
    tick();
    check("illegal ce hold2", {31'd0, count_en}, 32'd1);
    dice1_in = 3'd5;
    tick();
    check("illegal ce fall", {31'd0, count_en}, 32'd0);
    check("illegal dice1_q", {29'd0, dice1_q}, 32'd5);
    check("illegal sum", {28'd0, sum}, 32'd8);
    tick();
    check("illegal no decision", {30'd0, win, lose}, 32'd0);

    // new_game beats roll in PWAIT.
    new_game = 1'b1; roll = 1'b1; tick();
    new_game = 1'b0; roll = 1'b0;
    check("ng pwait count_en", {31'd0, count_en}, 32'd0);
    check("ng pwait point", {28'd0, point}, 32'd0);
    check("ng pwait roll_num", {24'd0, roll_num}, 32'd0);
    tick();
    check("ng pwait no roll", {31'd0, count_en}, 32'd0);

    // new_game during ROLL aborts with no capture.
    dice1_in = 3'd3; dice2_in = 3'd4;
    roll = 1'b1; repeat (3) tick();
    check("ng roll active", {31'd0, count_en}, 32'd1);
    new_game = 1'b1; roll = 1'b0; tick(); new_game = 1'b0;
    check("ng roll count_en", {31'd0, count_en}, 32'd0);
    repeat (6) tick();
    check("ng roll no capture sum", {28'd0, sum}, 32'd0);
    check("ng roll roll_num", {24'd0, roll_num}, 32'd0);
    check("ng roll win", {31'd0, win}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
